adc_spi_capture: RTL and testbench

ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

---
 rtl/adc_capture_pkg.sv | 16 +
 rtl/adc_sclk_gen.sv | 46 ++++
 rtl/adc_spi_capture.sv | 153 +++++++++++++++
 tb/tb_adc_spi_capture.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC SPI capture block.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FRAME_BITS    = 16;                     // bits per ADC word
  localparam int CONVST_CYCLES = 2;                      // convst strobe width
  localparam int AVG_LOG2      = 2;                      // log2 of frames averaged
  localparam int AVG_W         = FRAME_BITS + AVG_LOG2;  // accumulator width

endpackage

// File: rtl/adc_sclk_gen.sv
// SPI serial clock divider for the ADC readout.
// While en is high, sclk toggles every CLK_DIV cycles starting low. rise/fall
// are single-cycle enables asserted in the cycle before sclk changes, so the
// consumer acts on the same clk edge that moves sclk. edges_done goes high once
// FRAME_BITS rising edges have been issued in the current frame.
module adc_sclk_gen
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic edges_done
);

  logic [7:0] div_cnt;
  logic [4:0] rise_cnt;
  logic       half_end;

  assign half_end   = en && (div_cnt == 8'(CLK_DIV - 1));
  assign rise       = half_end && !sclk;
  assign fall       = half_end && sclk;
  assign edges_done = (rise_cnt == 5'(FRAME_BITS));

  // Half-period divider, sclk toggle and rising-edge counter; all cleared when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      sclk     <= 1'b0;
      rise_cnt <= '0;
    end else if (!en) begin
      div_cnt  <= '0;
      sclk     <= 1'b0;
      rise_cnt <= '0;
    end else begin
      div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
      if (half_end) sclk <= ~sclk;
      if (rise) rise_cnt <= rise_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Periodic ADC conversion trigger and 16-bit SPI readout.
// A period counter fires a trigger every SAMPLE_PERIOD cycles while sample_en
// is high. Each accepted trigger runs CONV (convst strobe, conversion wait),
// SHIFT (cs_n low, 16 sclk periods, sdo captured MSB first on sclk rise) and
// DONE (publish the word and pulse adc_ready). Triggers arriving while a frame
// is active are dropped and flagged in missed_trig.
// Trigger-to-ready latency: 2 (trigger register + IDLE->CONV) + CONV_CYCLES
// + 32*CLK_DIV + 1 (DONE) cycles.
// Build option: define ADC_AVG_EN to average 4 frames per adc_ready.
module adc_spi_capture
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int CONV_CYCLES   = 40,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic        adc_sdo,
  output logic        adc_convst,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] adc_data,
  output logic        adc_ready,
  output logic        missed_trig
);

  localparam int PER_W = $clog2(SAMPLE_PERIOD);

  state_t                  state, state_next;
  logic [PER_W-1:0]        per_cnt;
  logic                    trig;
  logic [15:0]             conv_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    sclk_rise, sclk_fall, sclk_edges_done;
  logic                    shift_end;

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk        (clk),
    .rst        (rst),
    .en         (state == SHIFT),
    .sclk       (adc_sclk),
    .rise       (sclk_rise),
    .fall       (sclk_fall),
    .edges_done (sclk_edges_done)
  );

  // Frame ends on the falling edge that follows the 16th rising edge.
  assign shift_end  = sclk_fall && sclk_edges_done;
  assign adc_convst = (state == CONV) && (conv_cnt < 16'(CONVST_CYCLES));
  assign adc_cs_n   = (state != SHIFT);

  // Period counter and registered trigger; counter parks at 0 while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      trig    <= 1'b0;
    end else if (!sample_en) begin
      per_cnt <= '0;
      trig    <= 1'b0;
    end else begin
      trig    <= (per_cnt == '0);
      per_cnt <= (per_cnt == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : per_cnt + PER_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trig) state_next = CONV;
      CONV:    if (conv_cnt == 16'(CONV_CYCLES - 1)) state_next = SHIFT;
      SHIFT:   if (shift_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion wait counter, running only in CONV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                conv_cnt <= '0;
    else if (state == CONV) conv_cnt <= conv_cnt + 16'd1;
    else                    conv_cnt <= '0;
  end

  // Serial capture, MSB first, on each sclk rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            shreg <= '0;
    else if (sclk_rise) shreg <= {shreg[FRAME_BITS-2:0], adc_sdo};
  end

  // Sticky dropped-trigger flag; sample_en low clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         missed_trig <= 1'b0;
    else if (!sample_en)             missed_trig <= 1'b0;
    else if (trig && state != IDLE)  missed_trig <= 1'b1;
  end

`ifdef ADC_AVG_EN
  logic [AVG_W-1:0]    sum;
  logic [AVG_W-1:0]    sum_next;
  logic [AVG_LOG2-1:0] frame_cnt;

  assign sum_next = sum + AVG_W'(shreg);

  // Accumulate 4 frames, publish the truncated mean, then restart the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      frame_cnt <= '0;
      adc_data  <= '0;
      adc_ready <= 1'b0;
    end else begin
      adc_ready <= 1'b0;
      if (state == DONE) begin
        if (&frame_cnt) begin
          adc_data  <= sum_next[AVG_W-1:AVG_LOG2];
          adc_ready <= 1'b1;
          sum       <= '0;
          frame_cnt <= '0;
        end else begin
          sum       <= sum_next;
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else if (!sample_en) begin
        sum       <= '0;
        frame_cnt <= '0;
      end
    end
  end
`else
  // Publish every completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_data  <= '0;
      adc_ready <= 1'b0;
    end else begin
      adc_ready <= (state == DONE);
      if (state == DONE) adc_data <= shreg;
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture. Instance dut uses default
// parameters; dut_b uses SAMPLE_PERIOD=100 to force dropped triggers.
// Define ADC_AVG_EN to exercise the 4-frame averaging build.
module tb_adc_spi_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_en = 1'b0, sample_en_b = 1'b0;
  logic sdo = 1'b0, sdo_b = 1'b0;
  logic convst, cs_n, sclk, ready, missed;
  logic convst_b, cs_n_b, sclk_b, ready_b, missed_b;
  logic [15:0] data, data_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] word = 16'h0, word_b = 16'h0;
  int bitp = 0, bitp_b = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adc_spi_capture dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .adc_sdo(sdo),
    .adc_convst(convst), .adc_cs_n(cs_n), .adc_sclk(sclk),
    .adc_data(data), .adc_ready(ready), .missed_trig(missed)
  );

  adc_spi_capture #(.CLK_DIV(4), .CONV_CYCLES(40), .SAMPLE_PERIOD(100)) dut_b (
    .clk(clk), .rst(rst), .sample_en(sample_en_b), .adc_sdo(sdo_b),
    .adc_convst(convst_b), .adc_cs_n(cs_n_b), .adc_sclk(sclk_b),
    .adc_data(data_b), .adc_ready(ready_b), .missed_trig(missed_b)
  );

  // ADC models: MSB presented at cs_n fall, next bit after each sclk fall.
  always @(negedge cs_n) begin bitp = 15; sdo = word[15]; end
  always @(negedge sclk) if (!cs_n && bitp > 0) begin bitp = bitp - 1; sdo = word[bitp]; end
  always @(negedge cs_n_b) begin bitp_b = 15; sdo_b = word_b[15]; end
  always @(negedge sclk_b) if (!cs_n_b && bitp_b > 0) begin bitp_b = bitp_b - 1; sdo_b = word_b[bitp_b]; end

  // Bounded wait for adc_ready of the selected instance, sampled on negedge.
  task automatic wait_ready(input bit b, input int max, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if ((b ? ready_b : ready) === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({convst, cs_n, sclk, ready, missed, data} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_dut: got convst=%b cs_n=%b sclk=%b ready=%b missed=%b data=%h want 0 1 0 0 0 0000",
               convst, cs_n, sclk, ready, missed, data);
    end
    checks++;
    if ({convst_b, cs_n_b, sclk_b, ready_b, missed_b, data_b} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_dut_b: got convst=%b cs_n=%b sclk=%b ready=%b missed=%b data=%h want 0 1 0 0 0 0000",
               convst_b, cs_n_b, sclk_b, ready_b, missed_b, data_b);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || convst !== 1'b0) begin
      errors++;
      $display("FAIL idle_disabled: got cs_n=%b convst=%b want 1 0", cs_n, convst);
    end
  endtask

`ifdef ADC_AVG_EN
  task automatic test_avg();
    logic [15:0] avg_words [4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0002};
    int t0, n;
    bit ok;
    exp_q.push_back(16'h8000);
    word = avg_words[0];
    @(posedge clk); #1;
    sample_en = 1'b1;
    t0 = cyc;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (cs_n !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      while (cs_n !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      word = avg_words[f + 1];
    end
    wait_ready(1'b0, 1000, ok);
    checks++;
    if (!ok || (cyc - t0) != 771) begin
      errors++;
      $display("FAIL avg_latency: got ok=%0d cycles=%0d want 771", ok, cyc - t0);
    end
    checks++;
    if (data !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL avg_data: got %h want 8000", data);
    end
    sample_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask
`else
  task automatic test_periodic();
    int t0;
    bit ok;
    logic [15:0] exp;
    word = 16'h5555;
    exp_q.push_back(16'h5555);
    exp_q.push_back(16'h5555);
    @(posedge clk); #1;
    sample_en = 1'b1;
    t0 = cyc;
    wait_ready(1'b0, 400, ok);
    checks++;
    if (!ok || (cyc - t0) != 171) begin
      errors++;
      $display("FAIL first_latency: got ok=%0d cycles=%0d want 171", ok, cyc - t0);
    end
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL first_data: got %h want %h", data, exp); end
    t0 = cyc;
    wait_ready(1'b0, 400, ok);
    checks++;
    if (!ok || (cyc - t0) != 200) begin
      errors++;
      $display("FAIL period: got ok=%0d cycles=%0d want 200", ok, cyc - t0);
    end
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL second_data: got %h want %h", data, exp); end
    checks++;
    if (missed !== 1'b0) begin errors++; $display("FAIL no_missed: got %b want 0", missed); end
    sample_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_order_convst();
    int t0, hi, first;
    bit ok;
    logic [15:0] exp;
    word = 16'h8001;
    exp_q.push_back(16'h8001);
    hi = 0;
    first = -1;
    ok = 1'b0;
    @(posedge clk); #1;
    sample_en = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (convst === 1'b1) begin
        hi++;
        if (first < 0) first = cyc - t0;
      end
      if (ready === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL convst_start: got %0d want 2", first); end
    checks++;
    if (hi != 2) begin errors++; $display("FAIL convst_width: got %0d want 2", hi); end
    checks++;
    if (!ok || (cyc - t0) != 171) begin
      errors++;
      $display("FAIL order_latency: got ok=%0d cycles=%0d want 171", ok, cyc - t0);
    end
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin errors++; $display("FAIL bit_order: got %h want %h", data, exp); end
    sample_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stop_mid();
    int rdy_n, cv_n;
    logic [15:0] got, exp;
    word = 16'hAAAA;
    exp_q.push_back(16'hAAAA);
    rdy_n = 0;
    cv_n = 0;
    got = 16'h0;
    @(posedge clk); #1;
    sample_en = 1'b1;
    repeat (72) @(negedge clk);
    checks++;
    if (cs_n !== 1'b0) begin errors++; $display("FAIL stop_in_shift: got cs_n=%b want 0", cs_n); end
    sample_en = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin rdy_n++; got = data; end
      if (convst === 1'b1) cv_n++;
    end
    checks++;
    if (rdy_n != 1) begin errors++; $display("FAIL stop_ready_count: got %0d want 1", rdy_n); end
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL stop_data: got %h want %h", got, exp); end
    checks++;
    if (cv_n != 0) begin errors++; $display("FAIL stop_convst: got %0d cycles want 0", cv_n); end
    checks++;
    if (cs_n !== 1'b1 || missed !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: got cs_n=%b missed=%b want 1 0", cs_n, missed);
    end
  endtask

  task automatic test_rst_shift();
    int rdy_n;
    word = 16'hFFFF;
    rdy_n = 0;
    @(posedge clk); #1;
    sample_en = 1'b1;
    repeat (104) @(negedge clk);
    checks++;
    if (cs_n !== 1'b0) begin errors++; $display("FAIL rst_pre_shift: got cs_n=%b want 0", cs_n); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({cs_n, sclk, ready, convst, data} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rst_async: got cs_n=%b sclk=%b ready=%b convst=%b data=%h want 1 0 0 0 0000",
               cs_n, sclk, ready, convst, data);
    end
    sample_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready === 1'b1) rdy_n++;
    end
    checks++;
    if (rdy_n != 0) begin errors++; $display("FAIL rst_no_ready: got %0d want 0", rdy_n); end
    checks++;
    if (data !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", data); end
  endtask

  task automatic test_missed();
    int t0;
    bit ok;
    logic [15:0] exp;
    word_b = 16'h1234;
    exp_q.push_back(16'h1234);
    @(posedge clk); #1;
    sample_en_b = 1'b1;
    t0 = cyc;
    repeat (50) @(negedge clk);
    checks++;
    if (missed_b !== 1'b0) begin errors++; $display("FAIL missed_before: got %b want 0", missed_b); end
    repeat (55) @(negedge clk);
    checks++;
    if (missed_b !== 1'b1) begin errors++; $display("FAIL missed_second_trig: got %b want 1", missed_b); end
    wait_ready(1'b1, 200, ok);
    checks++;
    if (!ok || (cyc - t0) != 171) begin
      errors++;
      $display("FAIL missed_latency: got ok=%0d cycles=%0d want 171", ok, cyc - t0);
    end
    exp = exp_q.pop_front();
    checks++;
    if (data_b !== exp) begin errors++; $display("FAIL missed_data: got %h want %h", data_b, exp); end
    sample_en_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (missed_b !== 1'b0) begin errors++; $display("FAIL missed_clear: got %b want 0", missed_b); end
    // Re-enable while a frame is still converting: first trigger is dropped.
    @(posedge clk); #1;
    sample_en_b = 1'b1;
    repeat (20) @(negedge clk);
    sample_en_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (missed_b !== 1'b0) begin errors++; $display("FAIL reenable_pre: got %b want 0", missed_b); end
    exp_q.push_back(16'h1234);
    sample_en_b = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (missed_b !== 1'b1) begin errors++; $display("FAIL reenable_missed: got %b want 1", missed_b); end
    wait_ready(1'b1, 300, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || data_b !== exp) begin
      errors++;
      $display("FAIL reenable_frame: got ok=%0d data=%h want 1 %h", ok, data_b, exp);
    end
    sample_en_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (missed_b !== 1'b0) begin errors++; $display("FAIL reenable_clear: got %b want 0", missed_b); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADC_AVG_EN
    test_avg();
`else
    test_periodic();
    test_order_convst();
    test_stop_mid();
    test_rst_shift();
    test_missed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
